// File: rtl/cpu_types_pkg.sv
// Shared datapath word types for the instruction-side memory hierarchy.
package cpu_types_pkg;
  localparam int WORD_W  = 32;
  localparam int IBYTE_W = 2;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/icache_way.sv
// One cache way across all sets: valid/tag/data storage, combinational match and read, word-write fill port.
// Read is zero-latency; writes land at the next edge; no backpressure (the owner sequences fills).
module icache_way
  import cpu_types_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2,
  parameter int TAG_W    = 26,
  parameter int IW       = 3,
  parameter int OW       = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IW-1:0]    rdidx,
  input  logic [TAG_W-1:0] rdtag,
  input  logic [OW-1:0]    rdoff,
  output logic             valid,
  output logic             match,
  output word_t            rdword,
  input  logic             wen,
  input  logic [IW-1:0]    widx,
  input  logic [OW-1:0]    woff,
  input  word_t            wdata,
  input  logic             commit,
  input  logic [TAG_W-1:0] wtag,
  input  logic             flush
);
  logic [SETS-1:0]  vbits;
  logic [TAG_W-1:0] tags [SETS];
  word_t            data [SETS][BLKWORDS];

  // Flush wins over a completing fill so an aborted block never turns valid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vbits <= '0;
    end else if (flush) begin
      vbits <= '0;
    end else if (commit) begin
      vbits[widx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wen) data[widx][woff] <= wdata;
    if (commit) tags[widx] <= wtag;
  end

  assign valid  = vbits[rdidx];
  assign match  = valid && (tags[rdidx] == rdtag);
  assign rdword = data[rdidx][rdoff];
endmodule

// File: rtl/icache_assoc.sv
// Set-associative icache with round-robin replacement, multi-word fill, flush and hit/miss counters.
// Hits are same-cycle; a miss holds iREN through BLKWORDS accepted words, each stalled by iwait.
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  input  logic  iflush,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);
  localparam int IW    = $clog2(SETS);
  localparam int OB    = $clog2(BLKWORDS);
  localparam int OW    = (OB > 0) ? OB : 1;
  localparam int WB    = $clog2(WAYS);
  localparam int WW    = (WB > 0) ? WB : 1;
  localparam int TAG_W = WORD_W - IBYTE_W - OB - IW;

  typedef enum logic {IDLE, FILL} state_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IW-1:0]    idx;
  } frame_t;

  state_t           state;
  frame_t           blk;
  logic [WW-1:0]    victim;
  logic             from_ptr;
  logic [OW-1:0]    cnt;
  logic [WW-1:0]    ptr [SETS];
  word_t            hit_cnt, miss_cnt;

  logic [TAG_W-1:0] rtag;
  logic [IW-1:0]    ridx;
  logic [OW-1:0]    roff;
  logic [WAYS-1:0]  hitv, vldv;
  word_t            rword [WAYS];
  word_t            hitword;
  logic             anyhit, miss, accept, last;
  logic [WW-1:0]    vict_sel;
  logic             vict_free;
  logic             unused_bits;

  assign rtag        = imemaddr[WORD_W-1 -: TAG_W];
  assign ridx        = imemaddr[IBYTE_W+OB +: IW];
  assign unused_bits = ^imemaddr[IBYTE_W-1:0];

  generate
    if (OB > 0) begin : g_off
      assign roff = imemaddr[IBYTE_W +: OW];
    end else begin : g_nooff
      assign roff = '0;
    end
  endgenerate

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_way #(
        .SETS(SETS), .BLKWORDS(BLKWORDS), .TAG_W(TAG_W), .IW(IW), .OW(OW)
      ) u_way (
        .CLK   (CLK),
        .nRST  (nRST),
        .rdidx (ridx),
        .rdtag (rtag),
        .rdoff (roff),
        .valid (vldv[w]),
        .match (hitv[w]),
        .rdword(rword[w]),
        .wen   (accept && (victim == WW'(w))),
        .widx  (blk.idx),
        .woff  (cnt),
        .wdata (iload),
        .commit(last && (victim == WW'(w))),
        .wtag  (blk.tag),
        .flush (iflush)
      );
    end
  endgenerate

  always_comb begin
    hitword   = '0;
    vict_sel  = ptr[ridx];
    vict_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (hitv[w]) hitword = hitword | rword[w];
    end
    // Descending scan leaves the lowest-numbered invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vldv[w]) begin
        vict_sel  = WW'(w);
        vict_free = 1'b1;
      end
    end
  end

  assign anyhit   = |hitv;
  assign ihit     = imemREN && (state == IDLE) && !iflush && anyhit;
  assign miss     = imemREN && (state == IDLE) && !iflush && !anyhit;
  assign imemload = ihit ? hitword : '0;
  assign accept   = (state == FILL) && !iwait && !iflush;
  assign last     = accept && (cnt == OW'(BLKWORDS - 1));

  assign iREN       = (state == FILL);
  assign iaddr      = (state == FILL) ? ((word_t'(blk) << (IBYTE_W + OB)) | (word_t'(cnt) << IBYTE_W)) : '0;
  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      blk      <= '0;
      victim   <= '0;
      from_ptr <= 1'b0;
      cnt      <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else begin
      if (ihit && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
      if (miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (miss) begin
            blk      <= '{tag: rtag, idx: ridx};
            victim   <= vict_sel;
            from_ptr <= !vict_free;
            cnt      <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (iflush) begin
            state <= IDLE;
          end else if (!iwait) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= IDLE;
              if (from_ptr) begin
                ptr[blk.idx] <= (ptr[blk.idx] == WW'(WAYS - 1)) ? '0 : ptr[blk.idx] + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (iflush) begin
        for (int s = 0; s < SETS; s++) ptr[s] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: directed fetches push expected data and fill addresses; monitors compare.
// Memory model returns addr ^ 32'hDEAD_0000 after lat_cfg stall cycles per word.
module tb_icache_assoc;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush = 1'b0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b0;
  logic [31:0] iload = '0;
  logic [31:0] hit_count, miss_count;

  int n_chk = 0;
  int n_fail = 0;
  int lat_cfg = 0;
  int stall = 0;
  logic [31:0] exp_dat[$];
  logic [31:0] exp_mem[$];
  logic        stalling = 1'b0;
  logic [31:0] held_addr = '0;

  icache_assoc #(.SETS(8), .WAYS(2), .BLKWORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iflush(iflush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory side: stall lat_cfg cycles, then present data for one accepting cycle.
  initial forever begin
    @(posedge CLK);
    #1;
    if (!iREN) begin
      iwait = 1'b0;
      stall = lat_cfg;
    end else if (stall > 0) begin
      iwait = 1'b1;
      stall--;
    end else begin
      iwait = 1'b0;
      iload = iaddr ^ 32'hDEAD_0000;
      stall = lat_cfg;
    end
  end

  // Fetch-side monitor.
  always @(negedge CLK) begin
    if (nRST && ihit) begin
      if (exp_dat.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_hit: got ihit=1 data %h expected no hit", imemload);
      end else begin
        chk("imemload", imemload, exp_dat.pop_front());
      end
    end
  end

  // Memory-side monitor: fill address order and stability under stall.
  always @(negedge CLK) begin
    if (nRST && iREN && iwait) begin
      if (stalling) chk("iaddr_stable", iaddr, held_addr);
      stalling  <= 1'b1;
      held_addr <= iaddr;
    end else if (nRST && iREN) begin
      stalling <= 1'b0;
      if (exp_mem.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_fill: got iaddr %h expected no memory read", iaddr);
      end else begin
        chk("iaddr", iaddr, exp_mem.pop_front());
      end
    end else begin
      stalling <= 1'b0;
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat, input bit is_miss);
    int cyc;
    bit got;
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = a;
    if (is_miss) begin
      exp_mem.push_back(a & ~32'h7);
      exp_mem.push_back((a & ~32'h7) + 32'h4);
    end
    exp_dat.push_back(d);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge CLK);
      if (cyc == 0) chk("iren_req_cycle", {31'b0, iREN}, 32'd0);
      if (cyc == 1) chk("iren_after_req", {31'b0, iREN}, {31'b0, is_miss});
      if (ihit) got = 1'b1;
      else begin
        @(posedge CLK);
        #1;
        cyc++;
      end
    end
    if (!got) begin
      void'(exp_dat.pop_back());
      $display("FAIL fetch_timeout: got no ihit for %h expected one within 200 cycles", a);
      n_fail++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Cold miss then refetch both words of the block.
    fetch(32'h0000_0040, 32'hDEAD_0040, 3, 1'b1);
    chk("miss_cnt_1", miss_count, 32'd1);
    fetch(32'h0000_0044, 32'hDEAD_0044, 0, 1'b0);
    fetch(32'h0000_0040, 32'hDEAD_0040, 0, 1'b0);
    chk("hit_cnt_3", hit_count, 32'd3);

    // Same index 0: free way first, then round-robin pointer 0,1,0.
    fetch(32'h0000_0140, 32'hDEAD_0140, 3, 1'b1);
    fetch(32'h0000_0240, 32'hDEAD_0240, 3, 1'b1);
    fetch(32'h0000_0140, 32'hDEAD_0140, 0, 1'b0);
    fetch(32'h0000_0040, 32'hDEAD_0040, 3, 1'b1);
    fetch(32'h0000_0240, 32'hDEAD_0240, 0, 1'b0);
    fetch(32'h0000_0140, 32'hDEAD_0140, 3, 1'b1);
    chk("miss_cnt_5", miss_count, 32'd5);

    // Three stall cycles per word.
    lat_cfg = 3;
    @(posedge CLK);
    fetch(32'h0000_0088, 32'hDEAD_0088, 9, 1'b1);
    lat_cfg = 0;
    @(posedge CLK);

    // Flush while the second word is accepted.
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0300;
    exp_mem.push_back(32'h0000_0300);
    exp_mem.push_back(32'h0000_0304);
    @(negedge CLK);
    chk("flush_req_ihit", {31'b0, ihit}, 32'd0);
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
    @(posedge CLK);
    #1;
    iflush = 1'b1;
    @(negedge CLK);
    chk("flush_cyc_iren", {31'b0, iREN}, 32'd1);
    @(posedge CLK);
    #1;
    iflush = 1'b0;
    @(negedge CLK);
    chk("flush_idle_iren", {31'b0, iREN}, 32'd0);
    chk("flush_idle_iaddr", iaddr, 32'd0);
    chk("miss_cnt_7", miss_count, 32'd7);
    fetch(32'h0000_0300, 32'hDEAD_0300, 3, 1'b1);
    fetch(32'h0000_0140, 32'hDEAD_0140, 3, 1'b1);
    chk("hit_cnt_12", hit_count, 32'd12);
    chk("miss_cnt_9", miss_count, 32'd9);

    // Flush in IDLE masks a hit and starts no fill.
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0300;
    iflush   = 1'b1;
    @(negedge CLK);
    chk("flush_masks_hit", {31'b0, ihit}, 32'd0);
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
    iflush  = 1'b0;
    @(negedge CLK);
    chk("flush_no_fill", {31'b0, iREN}, 32'd0);
    chk("flush_miss_cnt", miss_count, 32'd9);
    chk("flush_hit_cnt", hit_count, 32'd12);
    fetch(32'h0000_0300, 32'hDEAD_0300, 3, 1'b1);

    // Saturation of the hit counter.
    @(negedge CLK);
    force dut.hit_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt;
    fetch(32'h0000_0300, 32'hDEAD_0300, 0, 1'b0);
    chk("hit_sat_1", hit_count, 32'hFFFF_FFFF);
    fetch(32'h0000_0304, 32'hDEAD_0304, 0, 1'b0);
    chk("hit_sat_2", hit_count, 32'hFFFF_FFFF);

    // Reset asserted after the first word of a fill.
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0380;
    exp_mem.push_back(32'h0000_0380);
    @(negedge CLK);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("midrst_iren", {31'b0, iREN}, 32'd0);
    chk("midrst_iaddr", iaddr, 32'd0);
    chk("midrst_hits", hit_count, 32'd0);
    chk("midrst_misses", miss_count, 32'd0);
    imemREN = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    fetch(32'h0000_0380, 32'hDEAD_0380, 3, 1'b1);
    fetch(32'h0000_0300, 32'hDEAD_0300, 3, 1'b1);
    chk("end_miss_cnt", miss_count, 32'd2);

    repeat (2) @(posedge CLK);
    chk("dat_queue_empty", 32'(exp_dat.size()), 32'd0);
    chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
